// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared FSM encoding, exception codes and default parameters for multdiv_ctrl
package multdiv_pkg;
   typedef enum logic [1:0] {IDLE, START, BUSY, WB} state_t;
   localparam int TIMEOUT_DEF  = 40;
   localparam int RSTATUS_DEF  = 30;
   localparam int MULT_EXC_DEF = 4;
   localparam int DIV_EXC_DEF  = 5;
   localparam int TMO_EXC_DEF  = 6;
   localparam int CTR_W        = 6;
endpackage

// File: rtl/multdiv_ctrl_if.sv
// multdiv_ctrl_if: issue, multdiv-unit and writeback signals of multdiv_ctrl
interface multdiv_ctrl_if;
   logic        issue_valid, issue_mult, issue_div, issue_ready, stall, illegal;
   logic [31:0] issue_a, issue_b;
   logic [4:0]  issue_rd;
   logic        ctrl_MULT, ctrl_DIV;
   logic [31:0] data_operandA, data_operandB, md_result;
   logic        md_exception, md_resultRDY;
   logic        wb_valid, wb_ack, flush;
   logic [4:0]  wb_reg;
   logic [31:0] wb_data;
   modport slave (
      input  issue_valid, issue_mult, issue_div, issue_a, issue_b, issue_rd,
      input  md_result, md_exception, md_resultRDY, wb_ack, flush,
      output issue_ready, stall, illegal, ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
      output wb_valid, wb_reg, wb_data
   );
   modport master (
      output issue_valid, issue_mult, issue_div, issue_a, issue_b, issue_rd,
      output md_result, md_exception, md_resultRDY, wb_ack, flush,
      input  issue_ready, stall, illegal, ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
      input  wb_valid, wb_reg, wb_data
   );
endinterface

// File: rtl/md_timeout_ctr.sv
// md_timeout_ctr: wait-cycle counter with clear, enable and terminal count at TC-1
module md_timeout_ctr import multdiv_pkg::*; #(
   parameter int TC = TIMEOUT_DEF
) (
   input  logic clock,
   input  logic clrn,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tc
);
   logic [CTR_W-1:0] r_cnt;
   always_ff @(posedge clock or negedge clrn)
      if (!clrn) r_cnt <= '0;
      else if (i_clr) r_cnt <= '0;
      else if (i_en) r_cnt <= r_cnt + 1'b1;
   assign o_tc = r_cnt == CTR_W'(TC - 1);
endmodule

// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: sequences one mult/div through the multdiv unit and writes back result or exception code
module multdiv_ctrl import multdiv_pkg::*; #(
   parameter int TIMEOUT     = TIMEOUT_DEF,
   parameter int RSTATUS_REG = RSTATUS_DEF,
   parameter int MULT_EXC    = MULT_EXC_DEF,
   parameter int DIV_EXC     = DIV_EXC_DEF,
   parameter int TMO_EXC     = TMO_EXC_DEF
) (
   input logic            clock,
   input logic            clrn,
   multdiv_ctrl_if.slave  bus
);
   state_t      r_state;
   logic [31:0] r_a, r_b, r_result;
   logic [4:0]  r_rd, r_wb_reg;
   logic        r_mult, r_ctrl_mult, r_ctrl_div, r_illegal, r_stall, r_wb_valid;
   logic        w_bad, w_tc, w_exc;
   logic [31:0] w_exc_code;
   md_timeout_ctr #(.TC(TIMEOUT)) u_ctr (
      .clock(clock), .clrn(clrn), .i_clr(r_state == START), .i_en(r_state == BUSY), .o_tc(w_tc)
   );
   assign w_bad      = bus.issue_mult == bus.issue_div;
   // without RDY we only get here on terminal count, so that is the timeout case
   assign w_exc      = bus.md_resultRDY ? bus.md_exception : 1'b1;
   assign w_exc_code = !bus.md_resultRDY ? 32'(TMO_EXC) : r_mult ? 32'(MULT_EXC) : 32'(DIV_EXC);
   always_ff @(posedge clock or negedge clrn)
      if (!clrn) begin
         r_state     <= IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_rd        <= '0;
         r_mult      <= 1'b0;
         r_result    <= '0;
         r_wb_reg    <= '0;
         r_ctrl_mult <= 1'b0;
         r_ctrl_div  <= 1'b0;
         r_illegal   <= 1'b0;
         r_stall     <= 1'b0;
         r_wb_valid  <= 1'b0;
      end else begin
         r_ctrl_mult <= 1'b0;
         r_ctrl_div  <= 1'b0;
         r_illegal   <= 1'b0;
         case (r_state)
            IDLE: if (bus.issue_valid) begin
               if (w_bad) r_illegal <= 1'b1;
               else begin
                  r_state     <= START;
                  r_stall     <= 1'b1;
                  r_a         <= bus.issue_a;
                  r_b         <= bus.issue_b;
                  r_rd        <= bus.issue_rd;
                  r_mult      <= bus.issue_mult;
                  r_ctrl_mult <= bus.issue_mult;
                  r_ctrl_div  <= bus.issue_div;
               end
            end
            START: begin
               r_state <= bus.flush ? IDLE : BUSY;
               r_stall <= !bus.flush;
            end
            BUSY: if (bus.flush) begin
               r_state <= IDLE;
               r_stall <= 1'b0;
            end else if (bus.md_resultRDY || w_tc) begin
               r_wb_reg <= w_exc ? 5'(RSTATUS_REG) : r_rd;
               r_result <= w_exc ? w_exc_code : bus.md_result;
               if (!w_exc && r_rd == '0) begin
                  r_state <= IDLE;
                  r_stall <= 1'b0;
               end else begin
                  r_state    <= WB;
                  r_wb_valid <= 1'b1;
               end
            end
            WB: if (bus.flush || bus.wb_ack) begin
               r_state    <= IDLE;
               r_stall    <= 1'b0;
               r_wb_valid <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   assign bus.issue_ready   = !r_stall;
   assign bus.stall         = r_stall;
   assign bus.illegal       = r_illegal;
   assign bus.ctrl_MULT     = r_ctrl_mult;
   assign bus.ctrl_DIV      = r_ctrl_div;
   assign bus.data_operandA = r_a;
   assign bus.data_operandB = r_b;
   assign bus.wb_valid      = r_wb_valid;
   assign bus.wb_reg        = r_wb_reg;
   assign bus.wb_data       = r_result;
endmodule

// File: tb/tb_multdiv_ctrl.sv
// tb_multdiv_ctrl: directed vectors for multdiv_ctrl; writebacks are checked by a scoreboard monitor
module tb_multdiv_ctrl;
   logic clock = 1'b0;
   logic clrn  = 1'b0;
   multdiv_ctrl_if bus ();
   multdiv_ctrl dut (.clock(clock), .clrn(clrn), .bus(bus));
   always #5 clock = ~clock;

   typedef struct {logic [4:0] rd; logic [31:0] data;} wb_t;
   wb_t exp_q[$];
   wb_t cur;
   int  n_vec = 0, n_err = 0, n_mult = 0, n_div = 0;
   bit  in_wb = 1'b0;

   task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // monitor: counts ctrl pulses and scores every writeback against the queue
   always @(negedge clock) begin
      if (bus.ctrl_MULT) n_mult++;
      if (bus.ctrl_DIV) n_div++;
      if (bus.wb_valid && !in_wb) begin
         in_wb = 1'b1;
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL wb_unexpected: got reg %0d data %0d expected no writeback", bus.wb_reg, bus.wb_data);
            cur = '{bus.wb_reg, bus.wb_data};
         end else begin
            cur = exp_q.pop_front();
            check("wb_reg", bus.wb_reg, cur.rd);
            check("wb_data", bus.wb_data, cur.data);
         end
      end else if (bus.wb_valid) begin
         check("wb_reg_hold", bus.wb_reg, cur.rd);
         check("wb_data_hold", bus.wb_data, cur.data);
         check("wb_stall", bus.stall, 1);
      end
      if (!bus.wb_valid) in_wb = 1'b0;
   end

   task automatic tick(int n = 1);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic issue(bit m, bit d, logic [31:0] a, logic [31:0] b, logic [4:0] rd);
      bus.issue_valid = 1'b1;
      bus.issue_mult  = m;
      bus.issue_div   = d;
      bus.issue_a     = a;
      bus.issue_b     = b;
      bus.issue_rd    = rd;
      tick();
      bus.issue_valid = 1'b0;
      bus.flush       = 1'b0;
   endtask

   task automatic wait_idle(string nm);
      int i = 0;
      while (!bus.issue_ready && i < 100) begin
         tick();
         i++;
      end
      check({nm, "_idle"}, bus.issue_ready, 1);
   endtask

   // leaves the stale RDY of the previous op high through START; dly<=0 means RDY never comes
   task automatic do_op(string nm, bit m, logic [31:0] a, logic [31:0] b, logic [4:0] rd,
                        int dly, logic [31:0] res, bit exc, bit wb);
      issue(m, !m, a, b, rd);
      check({nm, "_ctrl_mult"}, bus.ctrl_MULT, m);
      check({nm, "_ctrl_div"}, bus.ctrl_DIV, !m);
      check({nm, "_opA"}, bus.data_operandA, a);
      check({nm, "_opB"}, bus.data_operandB, b);
      tick();
      bus.md_resultRDY = 1'b0;
      check({nm, "_ctrl_off"}, bus.ctrl_MULT | bus.ctrl_DIV, 0);
      if (dly > 0) begin
         if (dly > 1) tick(dly - 1);
         bus.md_resultRDY = 1'b1;
         bus.md_result    = res;
         bus.md_exception = exc;
         tick();
         check({nm, "_wb_valid"}, bus.wb_valid, wb);
      end
   endtask

   initial begin
      int i, m0, d0;
      bus.issue_valid  = 1'b0;
      bus.issue_mult   = 1'b0;
      bus.issue_div    = 1'b0;
      bus.issue_a      = '0;
      bus.issue_b      = '0;
      bus.issue_rd     = '0;
      bus.md_result    = 32'hDEAD;
      bus.md_exception = 1'b0;
      bus.md_resultRDY = 1'b1;
      bus.wb_ack       = 1'b1;
      bus.flush        = 1'b0;
      tick(2);
      check("rst_ready", bus.issue_ready, 1);
      check("rst_stall", bus.stall, 0);
      check("rst_wb_valid", bus.wb_valid, 0);
      check("rst_ctrl", bus.ctrl_MULT | bus.ctrl_DIV, 0);
      check("rst_illegal", bus.illegal, 0);
      check("rst_opA", bus.data_operandA, 0);
      clrn = 1'b1;
      tick();
      exp_q.push_back('{5'd5, 32'd42});
      do_op("mul", 1, 7, 6, 5, 3, 42, 0, 1);
      wait_idle("mul");
      check("mul_pulses", n_mult, 1);
      exp_q.push_back('{5'd30, 32'd5});
      do_op("div0", 0, 10, 0, 4, 2, 32'hFFFF_FFFF, 1, 1);
      wait_idle("div0");
      check("div_pulses", n_div, 1);
      bus.wb_ack = 1'b0;
      exp_q.push_back('{5'd9, 32'd15});
      do_op("ack", 1, 3, 5, 9, 1, 15, 0, 1);
      for (int k = 0; k < 4; k++) begin
         check("ack_stall", bus.stall, 1);
         check("ack_valid", bus.wb_valid, 1);
         tick();
      end
      bus.wb_ack = 1'b1;
      check("ack_last_valid", bus.wb_valid, 1);
      tick();
      check("ack_ready", bus.issue_ready, 1);
      check("ack_wb_off", bus.wb_valid, 0);
      do_op("rd0", 1, 9, 11, 0, 2, 99, 0, 0);
      wait_idle("rd0");
      exp_q.push_back('{5'd30, 32'd6});
      do_op("tmo", 1, 1, 2, 7, 0, 0, 0, 1);
      i = 0;
      while (!bus.wb_valid && i < 60) begin
         tick();
         i++;
      end
      check("tmo_busy_cycles", i, 40);
      wait_idle("tmo");
      do_op("fl", 0, 8, 2, 3, 0, 0, 0, 0);
      tick(2);
      bus.flush        = 1'b1;
      bus.md_resultRDY = 1'b1;
      bus.md_result    = 4;
      bus.md_exception = 1'b0;
      tick();
      bus.flush = 1'b0;
      check("fl_ready", bus.issue_ready, 1);
      check("fl_stall", bus.stall, 0);
      tick(3);
      check("fl_wb_off", bus.wb_valid, 0);
      do_op("rst", 1, 2, 2, 6, 0, 0, 0, 0);
      tick();
      clrn = 1'b0;
      #1;
      check("rstb_ready", bus.issue_ready, 1);
      check("rstb_stall", bus.stall, 0);
      check("rstb_opA", bus.data_operandA, 0);
      tick();
      clrn = 1'b1;
      bus.md_resultRDY = 1'b1;
      bus.md_result    = 4;
      tick(3);
      check("rstb_wb_off", bus.wb_valid, 0);
      check("rstb_idle", bus.issue_ready, 1);
      m0 = n_mult;
      d0 = n_div;
      issue(1, 1, 5, 5, 1);
      check("ill_both", bus.illegal, 1);
      check("ill_ready", bus.issue_ready, 1);
      tick();
      check("ill_pulse_end", bus.illegal, 0);
      issue(0, 0, 5, 5, 1);
      check("ill_none", bus.illegal, 1);
      tick();
      check("ill_no_ctrl", (n_mult - m0) + (n_div - d0), 0);
      exp_q.push_back('{5'd2, 32'd5});
      bus.flush = 1'b1;
      do_op("fidle", 0, 20, 4, 2, 1, 5, 0, 1);
      wait_idle("fidle");
      tick(2);
      check("queue_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/multdiv_ctrl.md
MULTDIV_CTRL -- requirements
Module: multdiv_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 40, meaning max cycles waited for md_resultRDY after a start pulse.
REQ-002 SHALL have parameter RSTATUS_REG, default 30, meaning register index written on exception.
REQ-003 SHALL have parameters MULT_EXC 4, DIV_EXC 5, TMO_EXC 6, meaning the rstatus codes for mult overflow, div-by-zero and timeout.
REQ-004 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port clrn, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have ports issue_valid, issue_mult, issue_div (input, 1 each), meaning the pipeline's operation request.
REQ-007 SHALL have ports issue_a, issue_b (input, 32 each) and issue_rd (input, 5), meaning the operands and destination register.
REQ-008 SHALL have port issue_ready, output, 1, meaning the block can accept a request this cycle.
REQ-009 SHALL have port stall, output, 1, meaning hold the pipeline.
REQ-010 SHALL have port illegal, output, 1, meaning a one-cycle pulse on rejected issue.
REQ-011 SHALL have ports ctrl_MULT, ctrl_DIV (output, 1 each) and data_operandA, data_operandB (output, 32 each), all driving the multdiv unit.
REQ-012 SHALL have ports md_result (input, 32) and md_exception, md_resultRDY (input, 1 each), taken from the multdiv unit.
REQ-013 SHALL have ports wb_valid (output, 1), wb_reg (output, 5), wb_data (output, 32) and wb_ack (input, 1), forming the writeback handshake.
REQ-014 SHALL have port flush, input, 1, meaning abandon the in-flight operation.

Function
REQ-015 SHALL implement FSM states IDLE, START, BUSY, WB.
REQ-016 SHALL assert issue_ready only in IDLE; stall = (state != IDLE).
REQ-017 SHALL accept on issue_valid & issue_ready with exactly one of issue_mult/issue_div high, latching a, b, rd and op, then moving to START.
REQ-018 SHALL treat issue_valid with both or neither op bit high as rejected: stay IDLE, pulse illegal for one cycle.
REQ-019 SHALL hold data_operandA/B at the latched operands from START until the next accept.
REQ-020 SHALL assert ctrl_MULT or ctrl_DIV (per latched op) for exactly the one START cycle, and never both.
REQ-021 SHALL ignore md_resultRDY in START (stale ready from the previous op), then move to BUSY.
REQ-022 SHALL clear the wait counter on entering BUSY and increment it each BUSY cycle.
REQ-023 SHALL, in BUSY with md_resultRDY high, capture md_result and md_exception and move to WB.
REQ-024 SHALL, in BUSY with counter == TIMEOUT-1 and no md_resultRDY, move to WB with a timeout exception; RDY in that same cycle wins.
REQ-025 SHALL, on a non-exception result with rd == 0, skip WB and go directly to IDLE.
REQ-026 SHALL, in WB, drive wb_valid=1; on no exception, wb_reg=rd and wb_data=result.
REQ-027 SHALL, in WB on exception, drive wb_reg=RSTATUS_REG and wb_data=MULT_EXC, DIV_EXC or TMO_EXC (zero-extended).
REQ-028 SHALL hold wb_valid, wb_reg and wb_data stable until wb_ack, then go to IDLE in the following cycle.
REQ-029 SHALL, on flush in START, BUSY or WB, go to IDLE next cycle with no writeback.
REQ-030 SHALL give flush priority over md_resultRDY and wb_ack.
REQ-031 SHALL ignore flush in IDLE, with issue still accepted that cycle.
REQ-032 SHALL give a minimum latency from accept to wb_valid of 3 cycles (START, BUSY with RDY, WB).

Reset
REQ-033 SHALL, on clrn low, immediately force state IDLE.
REQ-034 SHALL, on clrn low, immediately clear the counter, latched operands/rd/op/result, ctrl_MULT, ctrl_DIV, wb_valid, illegal and stall to 0; issue_ready becomes 1.
REQ-035 SHALL, on reset mid-operation, produce no writeback; md_resultRDY arriving after reset release in IDLE is ignored.

Structure
REQ-036 SHALL place the state enum, exception-code constants and TIMEOUT default in shared package multdiv_pkg.
REQ-037 SHALL use one sub-module md_timeout_ctr: a 6-bit counter with clear, enable and terminal-count output.

Verification
REQ-038 SHALL cover: accept mult a=7, b=6, rd=5; RDY 3 cycles after the pulse -> single ctrl_MULT pulse, then wb_reg=5, wb_data=42.
REQ-039 SHALL cover: div a=10, b=0, rd=4, md_exception=1 -> wb_reg=30, wb_data=5.
REQ-040 SHALL cover: wb_ack delayed 4 cycles -> wb fields stable, stall=1 throughout; IDLE one cycle after ack.
REQ-041 SHALL cover: mult rd=0 without exception -> no wb_valid; RDY never arrives -> after 40 BUSY cycles, wb_data=6 to reg 30.
REQ-042 SHALL cover: flush in BUSY, and separately clrn low in BUSY -> IDLE, no wb_valid, issue_ready=1; issue_mult=issue_div=1 -> illegal pulse, no ctrl pulse.
